// File: rtl/rand_event_ctrl.sv
// Random-event scheduler: a free-running prescaler tick steps an LFSR, and each round waits
// MIN_WAIT+rnd[4:0] ticks, raises evt, then times ack (hit/miss/early, reaction in ticks).
module rand_event_ctrl #(
  parameter int PRESCALE = 50000,
  parameter int MIN_WAIT = 4,
  parameter int TIMEOUT  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       ack,
  output logic       tick,
  output logic [9:0] rnd,
  output logic       evt,   // "event" is a reserved word in SystemVerilog
  output logic       busy,
  output logic       hit,
  output logic       miss,
  output logic       early,
  output logic [7:0] react
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int WW = $clog2(MIN_WAIT + 32) + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ARMED} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pcnt;
  logic [WW-1:0] wcnt, wcnt_nxt;
  logic [7:0]    react_nxt, react_inc;
  logic          hit_nxt, miss_nxt, early_nxt;

  assign tick = (pcnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  // Taps 0 and 3 give the maximal 1023-state sequence; zero is unreachable from 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd <= 10'd1;
    end else if (tick) begin
      rnd <= {rnd[0] ^ rnd[3], rnd[9:1]};
    end
  end

  assign react_inc = react + 8'd1;

  always_comb begin
    state_nxt = state;
    wcnt_nxt  = wcnt;
    react_nxt = react;
    hit_nxt   = 1'b0;
    miss_nxt  = 1'b0;
    early_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          wcnt_nxt  = WW'(MIN_WAIT) + WW'(rnd[4:0]);
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (ack) begin
          early_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else if (tick) begin
          if (wcnt == WW'(1)) begin
            react_nxt = 8'd0;
            state_nxt = S_ARMED;
          end else begin
            wcnt_nxt = wcnt - WW'(1);
          end
        end
      end
      S_ARMED: begin
        if (ack) begin
          hit_nxt   = 1'b1;
          state_nxt = S_IDLE;
        end else if (tick) begin
          react_nxt = react_inc;
          if (react_inc == 8'(TIMEOUT)) begin
            miss_nxt  = 1'b1;
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      wcnt  <= '0;
      react <= 8'd0;
      hit   <= 1'b0;
      miss  <= 1'b0;
      early <= 1'b0;
    end else begin
      state <= state_nxt;
      wcnt  <= wcnt_nxt;
      react <= react_nxt;
      hit   <= hit_nxt;
      miss  <= miss_nxt;
      early <= early_nxt;
    end
  end

  assign busy = (state != S_IDLE);
  assign evt  = (state == S_ARMED);

endmodule

// File: tb/tb_rand_event_ctrl.sv
// Directed bench for rand_event_ctrl with PRESCALE=4, MIN_WAIT=2, TIMEOUT=5.
module tb_rand_event_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, ack;
  logic       tick, evt, busy, hit, miss, early;
  logic [9:0] rnd;
  logic [7:0] react;

  int checks = 0;
  int errors = 0;

  rand_event_ctrl #(.PRESCALE(4), .MIN_WAIT(2), .TIMEOUT(5)) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .tick(tick), .rnd(rnd), .evt(evt), .busy(busy),
    .hit(hit), .miss(miss), .early(early), .react(react)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, start, ack;
    logic       tick;
    logic [9:0] rnd;
    logic       evt, busy, hit, miss, early;
    logic [7:0] react;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic r, logic s, logic a, logic t, logic [9:0] n,
                             logic e, logic b, logic h, logic m, logic y, logic [7:0] rc);
    vec_t x;
    x.rst = r; x.start = s; x.ack = a; x.tick = t; x.rnd = n;
    x.evt = e; x.busy = b; x.hit = h; x.miss = m; x.early = y; x.react = rc;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Apply inputs, clock once, then settle just after the edge.
  task automatic cyc(input logic r, input logic s, input logic a);
    rst = r; start = s; ack = a;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; ack = 1'b0;
    #1;

    // reset, LFSR sequence and a hit round starting in the first cycle after reset
    for (int i = 0; i < 3; i++) vecs.push_back(v(1,0,0, 0,10'd1,   0,0,0,0,0,0));
    vecs.push_back(v(0,1,0, 0,10'd1,   0,1,0,0,0,0)); // e1 start, wcnt=3
    vecs.push_back(v(0,0,0, 0,10'd1,   0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 1,10'd1,   0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 0,10'd512, 0,1,0,0,0,0)); // e4
    vecs.push_back(v(0,0,0, 0,10'd512, 0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 0,10'd512, 0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 1,10'd512, 0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 0,10'd256, 0,1,0,0,0,0)); // e8
    vecs.push_back(v(0,0,0, 0,10'd256, 0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 0,10'd256, 0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 1,10'd256, 0,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 0,10'd128, 1,1,0,0,0,0)); // e12 armed
    vecs.push_back(v(0,0,0, 0,10'd128, 1,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 0,10'd128, 1,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 1,10'd128, 1,1,0,0,0,0));
    vecs.push_back(v(0,0,0, 0,10'd64,  1,1,0,0,0,1)); // e16
    vecs.push_back(v(0,0,0, 0,10'd64,  1,1,0,0,0,1));
    vecs.push_back(v(0,0,0, 0,10'd64,  1,1,0,0,0,1));
    vecs.push_back(v(0,0,0, 1,10'd64,  1,1,0,0,0,1));
    vecs.push_back(v(0,0,0, 0,10'd32,  1,1,0,0,0,2)); // e20
    vecs.push_back(v(0,0,1, 0,10'd32,  0,0,1,0,0,2)); // e21 ack -> hit
    vecs.push_back(v(0,0,0, 0,10'd32,  0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 1,10'd32,  0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 0,10'd16,  0,0,0,0,0,2)); // e24
    vecs.push_back(v(0,0,0, 0,10'd16,  0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 0,10'd16,  0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 1,10'd16,  0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 0,10'd8,   0,0,0,0,0,2)); // e28
    vecs.push_back(v(0,0,0, 0,10'd8,   0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 0,10'd8,   0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 1,10'd8,   0,0,0,0,0,2));
    vecs.push_back(v(0,0,0, 0,10'd516, 0,0,0,0,0,2)); // e32

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].rst, vecs[i].start, vecs[i].ack);
      chk($sformatf("vec%0d", i),
          {8'd0, tick, rnd, evt, busy, hit, miss, early, react},
          {8'd0, vecs[i].tick, vecs[i].rnd, vecs[i].evt, vecs[i].busy,
           vecs[i].hit, vecs[i].miss, vecs[i].early, vecs[i].react});
    end

    // early press one tick into WAIT (rnd=516 -> wcnt=6), then start+ack in the result cycle
    for (int e = 33; e <= 36; e++) begin
      cyc(1'b0, e == 33, 1'b0);
      chk($sformatf("early_wait_e%0d", e), {evt, busy}, 2'b01);
    end
    cyc(1'b0, 1'b0, 1'b1); // e37
    chk("early_pulse", {evt, busy, hit, miss, early}, 5'b00001);
    chk("early_react_held", react, 8'd2);
    cyc(1'b0, 1'b1, 1'b1); // e38
    chk("start_ack_idle", {evt, busy, hit, miss, early}, 5'b01000);
    chk("lfsr_258", rnd, 10'd258);

    // miss after TIMEOUT ticks
    do_reset();
    for (int e = 1; e <= 31; e++) begin
      cyc(1'b0, e == 1, 1'b0);
      if (e == 12) chk("miss_armed", {evt, react}, {1'b1, 8'd0});
    end
    chk("miss_pre", {evt, miss, react}, {1'b1, 1'b0, 8'd4});
    cyc(1'b0, 1'b0, 1'b0); // e32
    chk("miss_pulse", {evt, busy, hit, miss, early}, 5'b00010);
    chk("miss_react", react, 8'd5);
    cyc(1'b0, 1'b0, 1'b0);
    chk("miss_after", {miss, react}, {1'b0, 8'd5});

    // start ignored in ARMED; ack on the timeout tick wins
    do_reset();
    for (int e = 1; e <= 12; e++) cyc(1'b0, e == 1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0); // e13
    chk("start_in_armed", {evt, busy, react}, {2'b11, 8'd0});
    for (int e = 14; e <= 31; e++) cyc(1'b0, 1'b0, 1'b0);
    chk("timeout_tick_pre", {tick, evt, react}, {2'b11, 8'd4});
    cyc(1'b0, 1'b0, 1'b1); // e32
    chk("ack_on_timeout", {evt, busy, hit, miss, early}, 5'b00100);
    chk("ack_on_timeout_react", react, 8'd4);

    // reset mid-round
    do_reset();
    for (int e = 1; e <= 17; e++) cyc(1'b0, e == 1, 1'b0);
    chk("pre_abort", {evt, react, rnd}, {1'b1, 8'd1, 10'd64});
    cyc(1'b1, 1'b0, 1'b0);
    chk("abort_flags", {tick, evt, busy, hit, miss, early}, 6'b000000);
    chk("abort_state", {rnd, react}, {10'd1, 8'd0});
    cyc(1'b0, 1'b0, 1'b0);
    chk("abort_no_pulse", {busy, hit, miss, early}, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
